pipeline_credit_receiver: RTL and testbench

- Sink-side companion for a stitched valid-only pipeline with fixed latency and no backpressure.
- Captures every pipeline result (pipe_out_valid/pipe_out) into a DEPTH-entry FIFO and presents it downstream with a ready/valid handshake.
- Meters upstream issue with credits, so no more than DEPTH items are ever in flight plus buffered, and no result is lost while the producer obeys up_in_ready.

---
 rtl/pipeline_credit_receiver.sv | 72 +++++++
 tb/tb_pipeline_credit_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_credit_receiver.sv
// pipeline_credit_receiver: credit-metered sink FIFO for a fixed-latency valid-only pipeline.
// Define PIPELINE_CREDIT_RECEIVER_CHECK_EN to build the issue/result latency checker.
module pipeline_credit_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_issue,
    output logic                  up_in_ready,
    input  logic                  pipe_out_valid,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    output logic                  dn_valid,
    output logic [DATA_WIDTH-1:0] dn_data,
    input  logic                  dn_ready,
    output logic [CW-1:0]         credits,
    output logic                  overflow,
    output logic                  protocol_err
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic                  pop, issue, push;

    assign dn_valid    = count != '0;
    assign dn_data     = mem[rd_ptr];
    assign up_in_ready = credits != '0;
    assign pop         = dn_valid & dn_ready;
    assign issue       = up_issue & up_in_ready;
    // a full FIFO still takes a result when the head leaves in the same cycle
    assign push        = pipe_out_valid & ((count != CW'(DEPTH)) | pop);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            credits  <= CW'(DEPTH);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            credits  <= credits + CW'(pop) - CW'(issue);
            count    <= count + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            overflow <= overflow | (pipe_out_valid & ~push);
        end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= pipe_out;

`ifdef PIPELINE_CREDIT_RECEIVER_CHECK_EN
    logic [LATENCY-1:0] tok;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tok          <= '0;
            protocol_err <= 1'b0;
        end else begin
            tok          <= LATENCY'({tok, issue});
            protocol_err <= protocol_err | (pipe_out_valid != tok[LATENCY-1]) | (up_issue & ~up_in_ready);
        end
`else
    // constant 0 for any legal LATENCY
    assign protocol_err = LATENCY < 1;
`endif
endmodule

// File: tb/tb_pipeline_credit_receiver.sv
// tb_pipeline_credit_receiver: directed scoreboard bench with a 3-cycle pipeline stand-in.
module tb_pipeline_credit_receiver;
    localparam int DW = 32;
    logic          clk = 0, rst = 0, up_issue = 0, dn_ready = 0, force_v = 0;
    logic          up_in_ready, pipe_out_valid, dn_valid, overflow, protocol_err;
    logic [DW-1:0] pipe_out, dn_data, issue_d = '0, force_d = '0, mon_exp;
    logic [2:0]    credits;
    logic [2:0]    pv;
    logic [DW-1:0] pd0, pd1, pd2;
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0, n_err = 0;

    pipeline_credit_receiver #(.DATA_WIDTH(DW), .DEPTH(4), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .up_issue(up_issue), .up_in_ready(up_in_ready),
        .pipe_out_valid(pipe_out_valid), .pipe_out(pipe_out), .dn_valid(dn_valid),
        .dn_data(dn_data), .dn_ready(dn_ready), .credits(credits),
        .overflow(overflow), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // pipeline stand-in: issue at edge N shows as a result sampled at edge N+3
    always @(posedge clk or negedge rst)
        if (!rst) pv <= '0;
        else begin
            pv  <= {pv[1:0], up_issue & up_in_ready};
            pd0 <= issue_d;
            pd1 <= pd0;
            pd2 <= pd1;
        end
    assign pipe_out_valid = pv[2] | force_v;
    assign pipe_out       = force_v ? force_d : pd2;

    always @(negedge clk)
        if (rst && dn_valid && dn_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_data: got %0h, required no pop (scoreboard empty)", dn_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dn_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL pop_data: got %0h, required %0h", dn_data, mon_exp);
                end
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [DW-1:0] d);
        up_issue = 1;
        issue_d  = d;
        exp_q.push_back(d);
        tick();
        up_issue = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        tick();
        exp_q.delete();
        rst = 1;
        tick();
    endtask

    initial begin
        tick();
        chk("rst_credits", credits, 4);
        chk("rst_up_ready", up_in_ready, 1);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_proto", protocol_err, 0);
        rst = 1;
        tick();
        // fill: 4 back-to-back issues, no drain
        for (int i = 0; i < 4; i++) begin
            chk("fill_credits", credits, 4 - i);
            if (i == 3) chk("fill_no_passthru", dn_valid, 0);
            issue(32'h10 + i);
        end
        chk("fill_first_visible", dn_valid, 1);
        chk("fill_credits_zero", credits, 0);
        chk("fill_up_ready", up_in_ready, 0);
        for (int i = 0; i < 3; i++) tick();
        up_issue = 1;
        tick();
        up_issue = 0;
        chk("sat_credits", credits, 0);
        chk("fill_overflow", overflow, 0);
        // drain
        dn_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_credits", credits, i + 1);
        end
        chk("drain_empty", dn_valid, 0);
        dn_ready = 0;
        // issue and pop in the same cycle at credits=2
        issue(32'h20);
        issue(32'h21);
        for (int i = 0; i < 3; i++) tick();
        chk("c2_credits", credits, 2);
        chk("c2_valid", dn_valid, 1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                dn_ready = 1;
                issue(32'h22 + 2 * r + k);
                chk("same_cycle_credits", credits, 2);
            end
            dn_ready = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("refill_credits", credits, 2);
            end
        end
        dn_ready = 1;
        tick();
        tick();
        dn_ready = 0;
        chk("c2_drained_credits", credits, 4);
        // overflow: forced result while full is dropped
        for (int i = 0; i < 4; i++) issue(32'h30 + i);
        for (int i = 0; i < 3; i++) tick();
        force_v = 1;
        force_d = 32'hAA;
        tick();
        force_v = 0;
        chk("ovf_set", overflow, 1);
        tick();
        chk("ovf_held", overflow, 1);
        dn_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_drain_empty", dn_valid, 0);
        dn_ready = 0;
        chk("ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);
        // full with a simultaneous pop accepts the result
        for (int i = 0; i < 4; i++) issue(32'h40 + i);
        for (int i = 0; i < 3; i++) tick();
        force_v  = 1;
        force_d  = 32'hAA;
        dn_ready = 1;
        exp_q.push_back(32'hAA);
        tick();
        force_v = 0;
        chk("full_pop_no_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("full_pop_empty", dn_valid, 0);
        dn_ready = 0;
        // mid-stream reset with 2 buffered and 1 in flight
        do_reset();
        for (int i = 0; i < 3; i++) issue(32'h50 + i);
        tick();
        tick();
        chk("pre_rst_credits", credits, 1);
        chk("pre_rst_valid", dn_valid, 1);
        rst = 0;
        #1;
        chk("async_rst_valid", dn_valid, 0);
        chk("async_rst_credits", credits, 4);
        chk("async_rst_ready", up_in_ready, 1);
        chk("async_rst_ovf", overflow, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1;
        tick();
        issue(32'h60);
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_valid", dn_valid, 1);
        dn_ready = 1;
        tick();
        dn_ready = 0;
        chk("post_rst_credits", credits, 4);
        // result with no matching issue
        do_reset();
        chk("proto_clean", protocol_err, 0);
        force_v = 1;
        force_d = 32'h77;
        exp_q.push_back(32'h77);
        tick();
        force_v = 0;
`ifdef PIPELINE_CREDIT_RECEIVER_CHECK_EN
        chk("proto_set", protocol_err, 1);
        tick();
        chk("proto_sticky", protocol_err, 1);
`else
        chk("proto_tied", protocol_err, 0);
        tick();
        chk("proto_tied_hold", protocol_err, 0);
`endif
        dn_ready = 1;
        tick();
        dn_ready = 0;
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
